pic_ctrl_param: RTL and testbench



---
 rtl/pic_pkg.sv | 45 ++++
 rtl/pic_priority_resolver.sv | 38 +++
 rtl/pic_ctrl_param.sv | 236 +++++++++++++++++++++++
 tb/tb_pic_ctrl_param.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// pic_pkg
// Shared definitions for the parametrised PIC control unit: controller state
// encoding, OCW2 command codes, command-word bit positions and a helper that
// ranks an IR level against the rotating lowest-priority pointer.
// No ports.
package pic_pkg;

  typedef enum logic [2:0] {
    ST_ICW1  = 3'd0,
    ST_ICW2  = 3'd1,
    ST_ICW4  = 3'd2,
    ST_READY = 3'd3,
    ST_ACK   = 3'd4
  } pic_state_e;

  // OCW2 command field din[7:5]
  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

  // Command-word bit positions
  localparam int ICW1_D4   = 4;
  localparam int ICW1_LTIM = 3;
  localparam int ICW1_IC4  = 0;
  localparam int ICW4_AEOI = 1;
  localparam int OCW_D3    = 3;
  localparam int OCW3_RR   = 1;
  localparam int OCW3_RIS  = 0;

  // Priority rank of a level: 0 is the level just above lp (highest).
  function automatic int unsigned pic_rank(input int unsigned id,
                                           input int unsigned lp,
                                           input int unsigned n);
    int unsigned t;
    t = id + n - 1 - lp;
    if (t >= n) t = t - n;
    return t;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver
// Combinational rotating priority encoder. The level directly above the
// lowest-priority pointer wins, searching upward with wrap-around.
// Ports:
//   i_req   request vector, one bit per IR level
//   i_lp    current lowest-priority level
//   o_valid at least one request bit is set
//   o_id    winning level
module pic_priority_resolver
  import pic_pkg::*;
#(
  parameter int NUM_IR = 8,
  parameter int IDW    = 3
) (
  input  logic [NUM_IR-1:0] i_req,
  input  logic [IDW-1:0]    i_lp,
  output logic              o_valid,
  output logic [IDW-1:0]    o_id
);

  int unsigned w_idx;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    o_valid = 1'b0;
    o_id    = '0;
    w_idx   = 0;
    for (int k = NUM_IR - 1; k >= 0; k--) begin
      w_idx = 32'(i_lp) + 32'(k) + 32'd1;
      if (w_idx >= 32'(NUM_IR)) w_idx = w_idx - 32'(NUM_IR);
      if (i_req[w_idx[IDW-1:0]]) begin
        o_valid = 1'b1;
        o_id    = w_idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/pic_ctrl_param.sv
// pic_ctrl_param
// Single 8259-style PIC control unit for NUM_IR request lines: ICW init
// sequence, IMR/IRR/ISR, rotating priority, EOI/rotation commands and the
// two-pulse INTA vector handshake.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   wr, rd, a0   one-cycle bus strobes and register select
//   din          write data
//   ir           interrupt requests (synchronous)
//   inta         one-cycle acknowledge pulse
//   dout         registered read/vector data, qualified by dout_vld
//   int_o        registered interrupt request to the CPU
//   init_done    initialisation complete (READY or ACK)
//
// state    | meaning
// ST_ICW1  | waiting for ICW1
// ST_ICW2  | waiting for vector base
// ST_ICW4  | waiting for ICW4 (only when IC4 set)
// ST_READY | normal operation, 1st INTA accepted here
// ST_ACK   | between 1st and 2nd INTA
module pic_ctrl_param
  import pic_pkg::*;
#(
  parameter int NUM_IR = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic              a0,
  input  logic [DATA_W-1:0] din,
  input  logic [NUM_IR-1:0] ir,
  input  logic              inta,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              int_o,
  output logic              init_done
);

  localparam int IDW = $clog2(NUM_IR);
  localparam int BW  = DATA_W - IDW;
  localparam logic [NUM_IR-1:0] ONE    = NUM_IR'(1);
  localparam logic [IDW-1:0]    TOP_ID = IDW'(NUM_IR - 1);

  pic_state_e r_state, w_state_nxt;

  logic [NUM_IR-1:0] r_imr, r_irr, r_isr, r_ir_d;
  logic [IDW-1:0]    r_lp, r_win;
  logic [BW-1:0]     r_base;
  logic              r_ltim, r_ic4, r_aeoi, r_rot_aeoi, r_ris, r_spur;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_vld, r_int;

  logic w_ready_ack, w_icw1, w_icw2, w_icw4, w_ocw1, w_ocw2, w_ocw3;
  logic w_inta1, w_inta2;
  logic w_req_vld, w_isr_vld, w_pending;
  logic [IDW-1:0] w_req_id, w_isr_id, w_lvl, w_lp_val;
  logic w_lvl_ok, w_lp_set, w_rot_set, w_rot_clr;
  logic [NUM_IR-1:0] w_eoi_clr, w_aeoi_clr, w_ack_set, w_edge, w_lvl_mask, w_isr_mask;
  logic [DATA_W-1:0] w_rd_data;

  assign w_ready_ack = (r_state == ST_READY) || (r_state == ST_ACK);
  assign w_icw1  = wr & ~a0 & din[ICW1_D4];
  assign w_icw2  = wr & a0 & (r_state == ST_ICW2);
  assign w_icw4  = wr & a0 & (r_state == ST_ICW4);
  assign w_ocw1  = wr & a0 & w_ready_ack;
  assign w_ocw2  = wr & ~a0 & ~din[ICW1_D4] & ~din[OCW_D3] & w_ready_ack;
  assign w_ocw3  = wr & ~a0 & ~din[ICW1_D4] &  din[OCW_D3] & w_ready_ack;
  // ICW1 aborts any handshake in progress, so it masks INTA in the same cycle.
  assign w_inta1 = inta & (r_state == ST_READY) & ~w_icw1;
  assign w_inta2 = inta & (r_state == ST_ACK) & ~w_icw1;

  pic_priority_resolver #(.NUM_IR(NUM_IR), .IDW(IDW)) u_req_res (
    .i_req   (r_irr & ~r_imr),
    .i_lp    (r_lp),
    .o_valid (w_req_vld),
    .o_id    (w_req_id)
  );

  pic_priority_resolver #(.NUM_IR(NUM_IR), .IDW(IDW)) u_isr_res (
    .i_req   (r_isr),
    .i_lp    (r_lp),
    .o_valid (w_isr_vld),
    .o_id    (w_isr_id)
  );

  // Fully nested: a request must strictly outrank the highest in-service level.
  assign w_pending = w_req_vld &
                     (~w_isr_vld ||
                      (pic_rank(32'(w_req_id), 32'(r_lp), NUM_IR) <
                       pic_rank(32'(w_isr_id), 32'(r_lp), NUM_IR)));

  assign w_ack_set  = (w_inta1 && w_pending) ? (ONE << w_req_id) : '0;
  assign w_aeoi_clr = (w_inta2 && r_aeoi && !r_spur) ? (ONE << r_win) : '0;
  assign w_edge     = ir & ~r_ir_d;

  assign w_lvl      = din[IDW-1:0];
  assign w_lvl_ok   = 32'(w_lvl) < 32'(NUM_IR);
  assign w_lvl_mask = w_lvl_ok ? (ONE << w_lvl) : '0;
  assign w_isr_mask = w_isr_vld ? (ONE << w_isr_id) : '0;

  always_comb begin
    w_eoi_clr = '0;
    w_lp_set  = 1'b0;
    w_lp_val  = r_lp;
    w_rot_set = 1'b0;
    w_rot_clr = 1'b0;
    if (w_ocw2) begin
      case (din[7:5])
        OCW2_NS_EOI:       w_eoi_clr = w_isr_mask;
        OCW2_SP_EOI:       w_eoi_clr = w_lvl_mask;
        OCW2_ROT_NS_EOI: begin
          w_eoi_clr = w_isr_mask;
          w_lp_set  = w_isr_vld;
          w_lp_val  = w_isr_id;
        end
        OCW2_ROT_SP_EOI: begin
          w_eoi_clr = w_lvl_mask;
          w_lp_set  = w_lvl_ok;
          w_lp_val  = w_lvl;
        end
        OCW2_SET_PRI: begin
          w_lp_set = w_lvl_ok;
          w_lp_val = w_lvl;
        end
        OCW2_ROT_AEOI_SET: w_rot_set = 1'b1;
        OCW2_ROT_AEOI_CLR: w_rot_clr = 1'b1;
        default:           ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_icw1) begin
      w_state_nxt = ST_ICW2;
    end else begin
      case (r_state)
        ST_ICW2:  if (w_icw2) w_state_nxt = r_ic4 ? ST_ICW4 : ST_READY;
        ST_ICW4:  if (w_icw4) w_state_nxt = ST_READY;
        ST_READY: if (w_inta1) w_state_nxt = ST_ACK;
        ST_ACK:   if (w_inta2) w_state_nxt = ST_READY;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_ICW1;
    else     r_state <= w_state_nxt;
  end

  assign w_rd_data = a0    ? DATA_W'(r_imr) :
                     r_ris ? DATA_W'(r_isr) : DATA_W'(r_irr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_imr      <= '0;
      r_irr      <= '0;
      r_isr      <= '0;
      r_ir_d     <= '0;
      r_lp       <= TOP_ID;
      r_win      <= '0;
      r_base     <= '0;
      r_ltim     <= 1'b0;
      r_ic4      <= 1'b0;
      r_aeoi     <= 1'b0;
      r_rot_aeoi <= 1'b0;
      r_ris      <= 1'b0;
      r_spur     <= 1'b0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
      r_int      <= 1'b0;
    end else begin
      r_ir_d <= ir;
      if (w_icw1) begin
        r_imr      <= '0;
        r_irr      <= '0;
        r_isr      <= '0;
        r_lp       <= TOP_ID;
        r_ltim     <= din[ICW1_LTIM];
        r_ic4      <= din[ICW1_IC4];
        r_aeoi     <= 1'b0;
        r_rot_aeoi <= 1'b0;
        r_ris      <= 1'b0;
      end else begin
        if (w_icw2) r_base <= din[DATA_W-1:IDW];
        if (w_icw4) r_aeoi <= din[ICW4_AEOI];
        if (w_ocw1) r_imr  <= din[NUM_IR-1:0];
        if (w_ocw3 && din[OCW3_RR]) r_ris <= din[OCW3_RIS];
        if (w_rot_set)      r_rot_aeoi <= 1'b1;
        else if (w_rot_clr) r_rot_aeoi <= 1'b0;
        // An explicit OCW2 pointer update beats the automatic AEOI rotation.
        if (w_lp_set)
          r_lp <= w_lp_val;
        else if (w_inta2 && r_aeoi && r_rot_aeoi && !r_spur)
          r_lp <= r_win;
        r_isr <= (r_isr & ~(w_eoi_clr | w_aeoi_clr)) | w_ack_set;
        // A fresh edge on the bit being acknowledged re-arms it.
        if (r_ltim) r_irr <= ir;
        else        r_irr <= (r_irr & ~w_ack_set) | w_edge;
        if (w_inta1) begin
          r_win  <= w_pending ? w_req_id : TOP_ID;
          r_spur <= ~w_pending;
        end
      end

      if (w_inta2) begin
        r_dout     <= {r_base, r_win};
        r_dout_vld <= 1'b1;
      end else if (rd) begin
        r_dout     <= w_rd_data;
        r_dout_vld <= 1'b1;
      end else begin
        r_dout_vld <= 1'b0;
      end

      if (w_icw1) begin
        r_int <= 1'b0;
      end else begin
        case (r_state)
          ST_READY: r_int <= w_pending;
          ST_ACK:   r_int <= r_int & ~inta;
          default:  r_int <= 1'b0;
        endcase
      end
    end
  end

  assign dout      = r_dout;
  assign dout_vld  = r_dout_vld;
  assign int_o     = r_int;
  assign init_done = w_ready_ack;

endmodule

// File: tb/tb_pic_ctrl_param.sv
module tb_pic_ctrl_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0, rd = 1'b0, a0 = 1'b0, inta = 1'b0;
  logic [7:0] din = '0, ir = '0, dout;
  logic       dout_vld, int_o, init_done;

  logic       wr4 = 1'b0, rd4 = 1'b0, a04 = 1'b0, inta4 = 1'b0;
  logic [7:0] din4 = '0, dout4;
  logic [3:0] ir4 = '0;
  logic       vld4, int4, done4;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state for the randomized test
  logic [7:0] m_imr, m_irr, m_isr;
  int         m_lp;

  always #5 clk = ~clk;

  pic_ctrl_param #(.NUM_IR(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .a0(a0), .din(din), .ir(ir),
    .inta(inta), .dout(dout), .dout_vld(dout_vld), .int_o(int_o),
    .init_done(init_done)
  );

  pic_ctrl_param #(.NUM_IR(4), .DATA_W(8)) dut4 (
    .clk(clk), .rst(rst), .wr(wr4), .rd(rd4), .a0(a04), .din(din4), .ir(ir4),
    .inta(inta4), .dout(dout4), .dout_vld(vld4), .int_o(int4),
    .init_done(done4)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input logic a, input logic [7:0] d);
    wr = 1'b1; a0 = a; din = d;
    cyc();
    wr = 1'b0; a0 = 1'b0; din = '0;
  endtask

  task automatic do_rd(input logic a, output logic [7:0] v, output logic vld);
    rd = 1'b1; a0 = a;
    cyc();
    rd = 1'b0; a0 = 1'b0;
    v = dout; vld = dout_vld;
  endtask

  task automatic do_ack(output logic [7:0] v, output logic vld);
    inta = 1'b1; cyc(); inta = 1'b0; cyc();
    inta = 1'b1; cyc(); inta = 1'b0;
    v = dout; vld = dout_vld;
  endtask

  task automatic pulse_ir(input logic [7:0] p);
    ir = p; cyc(); ir = '0; cyc();
  endtask

  task automatic init_std(input logic [7:0] icw1, input logic [7:0] icw4);
    do_wr(1'b0, icw1); do_wr(1'b1, 8'h40); do_wr(1'b1, icw4);
  endtask

  // highest-priority set bit of v given lowest-priority level lp, or -1
  function automatic int top_id(input logic [7:0] v, input int lp);
    for (int k = 1; k <= 8; k++) begin
      int id;
      id = (lp + k) % 8;
      if (v[id[2:0]]) return id;
    end
    return -1;
  endfunction

  function automatic int rnk(input int id, input int lp);
    return (id - lp + 7) % 8;
  endfunction

  function automatic logic m_pending();
    int r, s;
    r = top_id(m_irr & ~m_imr, m_lp);
    s = top_id(m_isr, m_lp);
    return (r >= 0) && (s < 0 || rnk(r, m_lp) < rnk(s, m_lp));
  endfunction

  task automatic test_reset();
    logic [7:0] v; logic vld;
    n_cmp++; if (int_o !== 1'b0) begin n_bad++; $display("FAIL rst_int: got %b exp 0", int_o); end
    n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b exp 0", init_done); end
    n_cmp++; if (dout !== 8'h00 || dout_vld !== 1'b0) begin n_bad++; $display("FAIL rst_dout: got %h/%b exp 00/0", dout, dout_vld); end
    rst = 1'b0;
    cyc();
    do_rd(1'b1, v, vld);
    n_cmp++; if (v !== 8'h00 || vld !== 1'b1) begin n_bad++; $display("FAIL rst_imr: got %h/%b exp 00/1", v, vld); end
  endtask

  task automatic test_init_basic();
    logic [7:0] v; logic vld;
    do_wr(1'b0, 8'h13);
    do_wr(1'b1, 8'h40);
    n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL init_icw4_wait: got %b exp 0", init_done); end
    do_wr(1'b1, 8'h01);
    n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL init_done: got %b exp 1", init_done); end
    ir = 8'h08; cyc();
    n_cmp++; if (int_o !== 1'b0) begin n_bad++; $display("FAIL basic_int_n1: got %b exp 0", int_o); end
    ir = 8'h00; cyc();
    n_cmp++; if (int_o !== 1'b1) begin n_bad++; $display("FAIL basic_int_n2: got %b exp 1", int_o); end
    do_ack(v, vld);
    n_cmp++; if (v !== 8'h43 || vld !== 1'b1) begin n_bad++; $display("FAIL basic_vec: got %h/%b exp 43/1", v, vld); end
    n_cmp++; if (int_o !== 1'b0) begin n_bad++; $display("FAIL basic_int_drop: got %b exp 0", int_o); end
    do_wr(1'b0, 8'h0B); do_rd(1'b0, v, vld);
    n_cmp++; if (v !== 8'h08) begin n_bad++; $display("FAIL basic_isr: got %h exp 08", v); end
    do_wr(1'b0, 8'h0A); do_rd(1'b0, v, vld);
    n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL basic_irr: got %h exp 00", v); end
    do_wr(1'b0, 8'h20); do_wr(1'b0, 8'h0B); do_rd(1'b0, v, vld);
    n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL basic_eoi: got %h exp 00", v); end
  endtask

  task automatic test_nesting();
    logic [7:0] v; logic vld;
    pulse_ir(8'h20);
    do_ack(v, vld);
    n_cmp++; if (v !== 8'h45) begin n_bad++; $display("FAIL nest_vec5: got %h exp 45", v); end
    pulse_ir(8'h04);
    n_cmp++; if (int_o !== 1'b1) begin n_bad++; $display("FAIL nest_int2: got %b exp 1", int_o); end
    do_ack(v, vld);
    n_cmp++; if (v !== 8'h42) begin n_bad++; $display("FAIL nest_vec2: got %h exp 42", v); end
    do_rd(1'b0, v, vld);
    n_cmp++; if (v !== 8'h24) begin n_bad++; $display("FAIL nest_isr: got %h exp 24", v); end
    do_ack(v, vld);
    n_cmp++; if (v !== 8'h47 || vld !== 1'b1) begin n_bad++; $display("FAIL spur_vec: got %h/%b exp 47/1", v, vld); end
    do_rd(1'b0, v, vld);
    n_cmp++; if (v !== 8'h24) begin n_bad++; $display("FAIL spur_isr: got %h exp 24", v); end
    pulse_ir(8'h40); cyc();
    n_cmp++; if (int_o !== 1'b0) begin n_bad++; $display("FAIL nest_block6: got %b exp 0", int_o); end
    do_wr(1'b0, 8'h20); cyc();
    n_cmp++; if (int_o !== 1'b0) begin n_bad++; $display("FAIL nest_still5: got %b exp 0", int_o); end
    do_wr(1'b0, 8'h20); cyc();
    n_cmp++; if (int_o !== 1'b1) begin n_bad++; $display("FAIL nest_int6: got %b exp 1", int_o); end
    do_ack(v, vld);
    n_cmp++; if (v !== 8'h46) begin n_bad++; $display("FAIL nest_vec6: got %h exp 46", v); end
    do_wr(1'b0, 8'h20);
  endtask

  task automatic test_mask_level();
    logic [7:0] v; logic vld;
    init_std(8'h1B, 8'h01);
    do_wr(1'b1, 8'h08);
    ir = 8'h08; cyc(); cyc(); cyc();
    n_cmp++; if (int_o !== 1'b0) begin n_bad++; $display("FAIL mask_int: got %b exp 0", int_o); end
    do_wr(1'b1, 8'h00); cyc();
    n_cmp++; if (int_o !== 1'b1) begin n_bad++; $display("FAIL unmask_int: got %b exp 1", int_o); end
    do_rd(1'b1, v, vld);
    n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL imr_rd: got %h exp 00", v); end
    do_rd(1'b0, v, vld);
    n_cmp++; if (v !== 8'h08) begin n_bad++; $display("FAIL level_irr: got %h exp 08", v); end
    do_wr(1'b0, 8'h0B);
    do_ack(v, vld);
    n_cmp++; if (v !== 8'h43) begin n_bad++; $display("FAIL level_vec: got %h exp 43", v); end
    do_rd(1'b0, v, vld);
    n_cmp++; if (v !== 8'h08) begin n_bad++; $display("FAIL level_isr: got %h exp 08", v); end
    ir = 8'h00; cyc();
    do_wr(1'b0, 8'h20); cyc();
    n_cmp++; if (int_o !== 1'b0) begin n_bad++; $display("FAIL level_idle: got %b exp 0", int_o); end
  endtask

  task automatic test_rotation();
    logic [7:0] v; logic vld;
    init_std(8'h13, 8'h01);
    do_wr(1'b0, 8'hC4);
    pulse_ir(8'h22);
    do_ack(v, vld);
    n_cmp++; if (v !== 8'h45) begin n_bad++; $display("FAIL rot_vec5: got %h exp 45", v); end
    do_wr(1'b0, 8'hA0);
    pulse_ir(8'h40);
    do_ack(v, vld);
    n_cmp++; if (v !== 8'h46) begin n_bad++; $display("FAIL rot_vec6: got %h exp 46", v); end
    do_wr(1'b0, 8'h20); cyc(); cyc();
    do_ack(v, vld);
    n_cmp++; if (v !== 8'h41) begin n_bad++; $display("FAIL rot_vec1: got %h exp 41", v); end
    do_wr(1'b0, 8'h20);
  endtask

  task automatic test_aeoi_abort();
    logic [7:0] v; logic vld;
    init_std(8'h13, 8'h03);
    do_wr(1'b0, 8'h80);
    pulse_ir(8'h04);
    do_ack(v, vld);
    n_cmp++; if (v !== 8'h42) begin n_bad++; $display("FAIL aeoi_vec: got %h exp 42", v); end
    do_wr(1'b0, 8'h0B); do_rd(1'b0, v, vld);
    n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL aeoi_isr: got %h exp 00", v); end
    pulse_ir(8'h0A);
    do_ack(v, vld);
    n_cmp++; if (v !== 8'h43) begin n_bad++; $display("FAIL aeoi_rot: got %h exp 43", v); end
    cyc(); cyc();
    do_ack(v, vld);
    n_cmp++; if (v !== 8'h41) begin n_bad++; $display("FAIL aeoi_next: got %h exp 41", v); end
    pulse_ir(8'h10);
    n_cmp++; if (int_o !== 1'b1) begin n_bad++; $display("FAIL abort_pre: got %b exp 1", int_o); end
    inta = 1'b1; cyc(); inta = 1'b0;
    do_wr(1'b0, 8'h13);
    n_cmp++; if (int_o !== 1'b0 || init_done !== 1'b0) begin n_bad++; $display("FAIL abort_drop: got %b/%b exp 0/0", int_o, init_done); end
    do_wr(1'b1, 8'h40); do_wr(1'b1, 8'h01);
    n_cmp++; if (init_done !== 1'b1 || int_o !== 1'b0) begin n_bad++; $display("FAIL abort_reinit: got %b/%b exp 1/0", init_done, int_o); end
    pulse_ir(8'h10);
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (int_o !== 1'b0 || init_done !== 1'b0) begin n_bad++; $display("FAIL async_rst: got %b/%b exp 0/0", int_o, init_done); end
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_num_ir4();
    wr4 = 1'b1; a04 = 1'b0; din4 = 8'h13; cyc();
    a04 = 1'b1; din4 = 8'h40; cyc();
    din4 = 8'h01; cyc();
    wr4 = 1'b0; a04 = 1'b0; din4 = '0;
    ir4 = 4'h8; cyc(); ir4 = 4'h0; cyc();
    n_cmp++; if (int4 !== 1'b1) begin n_bad++; $display("FAIL ir4_int: got %b exp 1", int4); end
    inta4 = 1'b1; cyc(); inta4 = 1'b0; cyc();
    inta4 = 1'b1; cyc(); inta4 = 1'b0;
    n_cmp++; if (dout4 !== 8'h43 || vld4 !== 1'b1) begin n_bad++; $display("FAIL ir4_vec: got %h/%b exp 43/1", dout4, vld4); end
  endtask

  task automatic test_random();
    logic [7:0] v, p; logic vld, exp_int;
    int w, t;
    init_std(8'h13, 8'h01);
    m_imr = '0; m_irr = '0; m_isr = '0; m_lp = 7;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        p = 8'($urandom_range(0, 255) & $urandom_range(0, 255) & $urandom_range(0, 255));
        do_wr(1'b1, p); m_imr = p;
      end
      if ($urandom_range(0, 3) == 0) begin
        t = $urandom_range(0, 7);
        do_wr(1'b0, 8'hC0 | 8'(t)); m_lp = t;
      end
      if (m_isr != 0 && $urandom_range(0, 3) == 0) begin
        do_wr(1'b0, 8'h20);
        t = top_id(m_isr, m_lp);
        m_isr[t[2:0]] = 1'b0;
      end
      p = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      pulse_ir(p);
      m_irr = m_irr | p;
      exp_int = m_pending();
      n_cmp++; if (int_o !== exp_int) begin n_bad++; $display("FAIL rnd_int it%0d: got %b exp %b", it, int_o, exp_int); end
      if (exp_int) begin
        w = top_id(m_irr & ~m_imr, m_lp);
        do_ack(v, vld);
        n_cmp++; if (v !== (8'h40 | 8'(w)) || vld !== 1'b1) begin n_bad++; $display("FAIL rnd_vec it%0d: got %h exp %h", it, v, 8'h40 | 8'(w)); end
        m_isr[w[2:0]] = 1'b1;
        m_irr[w[2:0]] = 1'b0;
        case ($urandom_range(0, 2))
          0: begin do_wr(1'b0, 8'h60 | 8'(w)); m_isr[w[2:0]] = 1'b0; end
          1: begin
            do_wr(1'b0, 8'h20);
            t = top_id(m_isr, m_lp);
            m_isr[t[2:0]] = 1'b0;
          end
          default: ;
        endcase
      end
    end
    do_wr(1'b0, 8'h0B); do_rd(1'b0, v, vld);
    n_cmp++; if (v !== m_isr) begin n_bad++; $display("FAIL rnd_isr: got %h exp %h", v, m_isr); end
    do_wr(1'b0, 8'h0A); do_rd(1'b0, v, vld);
    n_cmp++; if (v !== m_irr) begin n_bad++; $display("FAIL rnd_irr: got %h exp %h", v, m_irr); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cyc(); cyc();
    test_reset();
    test_init_basic();
    test_nesting();
    test_mask_level();
    test_rotation();
    test_aeoi_abort();
    test_num_ir4();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
